// File: rtl/mod100_disp_pkg.sv
// Shared types and constants for the mod-100 display driver.
// Build option: MOD100_DISP_BLANK_EN enables leading-zero blanking.
package mod100_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    localparam logic [6:0] MAX_COUNT   = 7'd99;
    localparam logic [2:0] SHIFT_ITERS = 3'd7;
    localparam logic [6:0] SEG_OFF     = 7'b0000000;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_DIGIT[d];
        end
        return SEG_OFF;
    endfunction

endpackage

// File: rtl/mod100_disp_driver_bin2bcd_seq.sv
// Capture, saturate and sequential double-dabble conversion.
// Produces committed tens/ones digits with a one-cycle done pulse.
module bin2bcd_seq
    import mod100_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic       range_err,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state;
    logic [14:0] scratch;
    logic [14:0] adj;
    logic [2:0]  iter;
    logic        over;

    assign over = (bin > MAX_COUNT);

    // Add-3 correction of each BCD nibble before the shift.
    always_comb begin
        adj = scratch;
        if (scratch[14:11] >= 4'd5) begin
            adj[14:11] = scratch[14:11] + 4'd3;
        end
        if (scratch[10:7] >= 4'd5) begin
            adj[10:7] = scratch[10:7] + 4'd3;
        end
    end

    // Converter FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scratch   <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            tens      <= '0;
            ones      <= '0;
        end else begin
            done      <= 1'b0;
            range_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= SHIFT;
                        busy      <= 1'b1;
                        iter      <= '0;
                        range_err <= over;
                        scratch   <= {8'd0, over ? MAX_COUNT : bin};
                    end
                end
                SHIFT: begin
                    scratch <= {adj[13:0], 1'b0};
                    iter    <= iter + 3'd1;
                    if (iter == SHIFT_ITERS - 3'd1) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    tens  <= scratch[14:11];
                    ones  <= scratch[10:7];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mod100_disp_driver.sv
// Two-digit multiplexed seven-segment driver for a 0..99 count.
// Build option: MOD100_DISP_BLANK_EN blanks a zero tens digit.
module mod100_disp_driver
    import mod100_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] count_in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       range_err,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

    logic [RW-1:0] rcnt;
    logic          wrap;
    logic [1:0]    an_next;
    logic [3:0]    digit;
    logic [6:0]    seg_next;

    bin2bcd_seq u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .bin       (count_in),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .tens      (bcd_tens),
        .ones      (bcd_ones)
    );

    // Select the next digit and its segment pattern.
    always_comb begin
        wrap     = (rcnt == RMAX);
        an_next  = wrap ? {an[0], an[1]} : an;
        digit    = an_next[1] ? bcd_tens : bcd_ones;
        seg_next = seg_encode(digit);
`ifdef MOD100_DISP_BLANK_EN
        if (an_next[1] && (bcd_tens == 4'd0)) begin
            seg_next = SEG_OFF;
        end
`endif
    end

    // Refresh counter and registered digit/segment outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            an   <= 2'b01;
            seg  <= SEG_DIGIT[0];
        end else begin
            rcnt <= wrap ? '0 : rcnt + 1'b1;
            an   <= an_next;
            seg  <= seg_next;
        end
    end

endmodule

// File: doc/mod100_disp_driver.md
# mod100_disp_driver

Downstream consumer of the mod-100 counter. Captures a 7-bit binary count (0–99), converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a two-digit common-segment seven-segment display. It sits between the counter's `count` output and the board display pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is enabled. Legal range is ≥2.
- `clk`  in  1  rising-edge system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `count_in`  in  7  binary value to display
- `load`  in  1  single-cycle strobe; sample `count_in`
- `busy`  out  1  conversion in progress
- `done`  out  1  one-cycle pulse when new BCD digits are committed
- `range_err`  out  1  one-cycle pulse when a sampled value is >99
- `bcd_tens`  out  4  committed tens digit
- `bcd_ones`  out  4  committed ones digit
- `seg`  out  7  active-high segments {g,f,e,d,c,b,a}
- `an`  out  2  active-high one-hot digit enable; 2'b01 = ones, 2'b10 = tens

## Operation
- Converter FSM states:
  - IDLE: `load=1` goes to SHIFT.
  - SHIFT: exactly 7 iterations, then COMMIT.
  - COMMIT: returns to IDLE.
- Capture:
  - A `load` in IDLE latches `count_in`.
  - If `count_in` > 99, the latched value saturates to 99 and `range_err` pulses on the capture edge.
- SHIFT iteration:
  - For each BCD nibble ≥5, add 3.
  - Then shift {tens, ones, bin} left by one.
  - The scratch register is 8 bits BCD plus 7 bits binary.
- COMMIT: copy the scratch BCD into `bcd_tens`/`bcd_ones` and pulse `done`.
- `load` while `busy=1` is ignored. It is not queued and raises no error.
- Reset values:
  - FSM is IDLE; `busy`, `done`, `range_err` = 0; `bcd_tens`/`bcd_ones` = 0.
  - `an` = 2'b01 and `seg` = 7'b0111111, so the display shows "00" (or " 0" with blanking).
  - Refresh counter = 0.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, `an` toggles between 01 and 10.
- Segment codes, 0–9:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F (hex)
  - Any non-BCD nibble drives 7'b0000000. This is unreachable by construction.
- Reset asserted mid-conversion aborts immediately to reset values. No `done` is issued.

## Timing
- Latency: with `load` sampled at edge N:
  - `busy`=1 from N through N+7.
  - SHIFT occupies edges N+1..N+7 and COMMIT is edge N+8.
  - `bcd_*` and `done` are valid after edge N+8.
  - `busy`=0 after N+8.
  - The next `load` is accepted at N+9 or later.
- Throughput: one conversion per 9 cycles.
- `seg` and `an` are registered and change on the same edge.
- `seg` reflects committed BCD one cycle after COMMIT, without waiting for a refresh wrap.
- `done` and `range_err` are never wider than one cycle.
- `range_err` never coincides with `done` of the same conversion.

## Configuration
- `MOD100_DISP_BLANK_EN` (leading-zero blanking):
  - Defined: when the committed `bcd_tens`==0 and `an`=2'b10, `seg`=7'b0000000. `an` keeps its normal timing.
  - Undefined: the tens digit always shows its code, so 0 appears as "0" on tens.
- BCD outputs are unaffected by the macro.

## Structure
- Package `mod100_disp_pkg` holds:
  - converter state enum (IDLE, SHIFT, COMMIT)
  - `SEG_*` constant array for digits 0–9
  - `SEG_OFF`
  - `MAX_COUNT`=99
  - shift-iteration count = 7
- Sub-module `bin2bcd_seq` holds the capture/saturate/double-dabble FSM, with ports clk, rst_n, load, bin, busy, done, range_err, tens, ones.
- The top level holds the refresh counter, digit select, seg encode and blanking.

## Test plan
- Reset release, then idle for 20 cycles with `REFRESH_DIV`=4:
  - `an` alternates 01/10 every 4 cycles.
  - `seg`=3F on both digits (tens=00 when blanking enabled).
  - `busy`=`done`=0.
- `load` with `count_in`=57 at edge N → `busy` N..N+7; `done` pulse at N+8; tens=5, ones=7; `seg` shows 6D on tens, 07 on ones.
- `count_in`=99, then 0, then 10 → 9/9, 0/0, 1/0. With `MOD100_DISP_BLANK_EN`, value 7 blanks tens (`seg`=00 while `an`=10).
- `count_in`=120 → `range_err` pulses on the capture edge; commit gives 9/9.
- `load`=42 at N, then `load`=13 at N+3 → only 4/2 is committed; one `done` pulse.
- `rst_n` low at N+4 of a conversion of 88 → `busy`=0, `bcd_*`=0, `seg`=3F, `an`=01 asynchronously; no `done` pulse.
